ap_ctrl_sequencer: RTL and testbench
====================================

// Module: ap_ctrl_sequencer
// PURPOSE
//  Drives an HLS kernel's ap_ctrl_hs/chain handshake (ap_start/ap_ready/ap_done/ap_continue) for a run of N back-to-back invocations.
//  Bounds in-flight invocations and tracks issued/completed counts and per-run cycles; a watchdog aborts stalled runs.
//  Sits between the testbench/host config and the kernel top; cosim monitors observe the same ap_* nets.
// PARAMETERS
//  CNT_W        16    width of invocation counters and cfg_num_txn
//  MAX_INFLIGHT 4     max issued-not-done invocations (power of 2, >=1)
//  TS_W         32    width of free-running cycle timestamp / run cycle counter
//  TIMEOUT      4096  cycles without ready/done progress before abort (>0)
// PORTS
//  clock          in   1      single clock, rising edge
//  reset          in   1      synchronous, active-high
//  cfg_start      in   1      pulse: begin run (ignored unless IDLE)
//  cfg_num_txn    in   CNT_W  invocations in run, sampled on accepted cfg_start
//  cfg_gap        in   8      idle cycles between issue handshakes, sampled with cfg_num_txn
//  sink_hold      in   1      1 = downstream stalled; ap_continue = ~sink_hold
//  ap_start       out  1      to kernel
//  ap_ready       in   1      from kernel: input accepted
//  ap_done        in   1      from kernel: output valid (held until ap_continue)
//  ap_continue    out  1      to kernel
//  busy           out  1      state != IDLE
//  run_done       out  1      1-cycle pulse at run end (normal or abort)
//  err_timeout    out  1      sticky; cleared by next accepted cfg_start
//  issued_cnt     out  CNT_W  ready handshakes this run
//  done_cnt       out  CNT_W  done handshakes this run
//  run_cycles     out  TS_W   cycles from cfg_start accept to run_done, saturating
// BEHAVIOUR
//  Reset: all outputs 0 except ap_continue = ~sink_hold; state IDLE; FIFO empty; counters 0.
//  Issue handshake = ap_start & ap_ready; completion handshake = ap_done & ap_continue.
//  FSM: IDLE -> ISSUE on cfg_start (num>0); IDLE -> DONE on cfg_start with num==0.
//   ISSUE: ap_start=1 iff inflight<MAX_INFLIGHT; held high until ap_ready, never dropped mid-handshake.
//   On issue: issued_cnt++; issued==num -> DRAIN; else cfg_gap>0 -> GAP; else stay ISSUE.
//   GAP: ap_start=0 for cfg_gap cycles, then ISSUE.  DRAIN: ap_start=0; done_cnt==num -> DONE.
//   DONE: run_done=1 for one cycle -> IDLE. Counters hold their values until the next accepted cfg_start.
//  inflight = issued - done, counted in all non-IDLE states. Same-cycle issue+completion leaves inflight unchanged.
//  ap_start reads combinationally from registered state/inflight; with MAX_INFLIGHT=1 it is 0 the cycle after an issue while inflight==1.
//  Watchdog: counter clears on any handshake or on state entry; reaching TIMEOUT in ISSUE/GAP/DRAIN sets err_timeout, then DONE.
//  run_cycles increments each non-IDLE cycle and saturates at all-ones.
//  cfg_start while busy: ignored, no effect on counters.
//  Completion with inflight==0 (spurious ap_done): ignored, done_cnt unchanged.
//  Reset mid-run: ap_start low the next cycle, all state cleared, no run_done pulse.
// CONFIGURATION
//  `AP_SEQ_LAT_STATS_EN defined: adds outputs lat_last/lat_min/lat_max [TS_W]. Each issue pushes the timestamp into a FIFO.
//   Each completion pops the FIFO; latency = now - head, mod 2^TS_W. Min resets to all-ones, max and last reset to 0.
//   Stats clear on an accepted cfg_start.
//  Undefined: no FIFO, no timestamp counter, no lat_* ports; the remaining behaviour is identical.
// STRUCTURE
//  Package ap_seq_pkg: state_e {IDLE,ISSUE,GAP,DRAIN,DONE}, GAP_W=8, localparam function clog2-based INFL_W.
//  Sub-module ap_seq_ts_fifo (depth MAX_INFLIGHT, width TS_W, push/pop same-cycle safe) is instantiated only under the macro.
// TESTING
//  1. num=4, gap=0, kernel ready same cycle as start, done 3 cycles later -> 4 issues, done_cnt=4, run_done once.
//  2. num=8, MAX_INFLIGHT=2, ap_done delayed 10 cycles -> ap_start low whenever inflight==2; never 3 in flight.
//  3. num=3, gap=2 -> exactly 2 ap_start-low cycles between consecutive issue handshakes.
//  4. sink_hold=1 for 20 cycles with ap_done high -> done_cnt frozen, ap_continue=0; resumes after release.
//  5. num=2, kernel never asserts ap_ready, TIMEOUT=16 -> err_timeout=1 and run_done 17 cycles after ISSUE entry.
//  6. num=0 -> run_done 1 cycle after cfg_start. Also: reset during DRAIN -> all outputs 0 and busy=0 next cycle.
//  Under the macro: fixed 5-cycle kernel latency -> lat_min=lat_max=lat_last=5.

Source files
------------

// File: rtl/ap_ctrl_sequencer_pkg.sv
// ap_seq_pkg: shared types and sizing helpers for the ap_ctrl sequencer.
//   state_e  : sequencer FSM states
//   GAP_W    : width of the inter-issue gap setting
//   infl_w() : width needed to hold an in-flight count of 0..max_inflight
package ap_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int GAP_W = 8;

    function automatic int infl_w(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/ap_ctrl_sequencer_if.sv
// ap_ctrl_sequencer_if: HLS block-level handshake (ap_ctrl_hs / ap_ctrl_chain).
//   ap_start    : sequencer -> kernel, request an invocation
//   ap_ready    : kernel -> sequencer, invocation inputs accepted
//   ap_done     : kernel -> sequencer, output valid (held until ap_continue)
//   ap_continue : sequencer -> kernel, downstream can take the output
// master = sequencer side, slave = kernel side.
interface ap_ctrl_sequencer_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (output ap_start, output ap_continue,
                    input  ap_ready, input  ap_done);
    modport slave  (input  ap_start, input  ap_continue,
                    output ap_ready, output ap_done);
endinterface

// File: rtl/ap_ctrl_sequencer_ts_fifo.sv
// ap_seq_ts_fifo: issue-timestamp FIFO for latency statistics.
//   clock, reset : clock / synchronous active-high reset
//   flush        : empty the FIFO (new run)
//   push, push_data : write one timestamp
//   pop          : drop the head entry
//   head         : oldest timestamp (valid while not empty)
// Push and pop may coincide; the head is read from the old read pointer, so
// a same-cycle push never disturbs the entry being popped. The caller never
// pushes when full nor pops when empty (occupancy mirrors the in-flight count).
module ap_seq_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: drives an HLS kernel's ap_start/ap_ready/ap_done/ap_continue
// handshake for a run of cfg_num_txn back-to-back invocations, bounding the
// number in flight, counting issues/completions and run cycles, and aborting
// a stalled run with a watchdog.
//   clock, reset   : clock / synchronous active-high reset
//   cfg_start      : pulse, begin a run (only accepted in IDLE)
//   cfg_num_txn    : invocations per run, sampled on accepted cfg_start
//   cfg_gap        : idle cycles between issues, sampled with cfg_num_txn
//   sink_hold      : downstream stall; ap_continue = ~sink_hold
//   ap             : kernel handshake (master modport)
//   busy           : state != IDLE
//   run_done       : one-cycle pulse at run end (normal or abort)
//   err_timeout    : sticky watchdog abort flag, cleared by next accepted cfg_start
//   issued_cnt     : issue handshakes this run
//   done_cnt       : completion handshakes this run
//   run_cycles     : non-IDLE cycles this run, saturating
// Optional (`AP_SEQ_LAT_STATS_EN): lat_last/lat_min/lat_max invocation latency
// measured from issue handshake to completion handshake.
//
// state | meaning
// IDLE  | waiting for cfg_start
// ISSUE | raising ap_start while below the in-flight limit
// GAP   | ap_start held low for cfg_gap cycles after an issue
// DRAIN | all issued, waiting for the remaining completions
// DONE  | run_done pulse, back to IDLE
module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MAX_INFLIGHT = 4,
    parameter int TS_W         = 32,
    parameter int TIMEOUT      = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_txn,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             sink_hold,
    ap_ctrl_sequencer_if.master ap,
    output logic             busy,
    output logic             run_done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [TS_W-1:0]  run_cycles
`ifdef AP_SEQ_LAT_STATS_EN
    ,
    output logic [TS_W-1:0]  lat_last,
    output logic [TS_W-1:0]  lat_min,
    output logic [TS_W-1:0]  lat_max
`endif
);
    localparam int INFL_W = infl_w(MAX_INFLIGHT);
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [INFL_W-1:0] INFL_MAX = INFL_W'(MAX_INFLIGHT);
    localparam logic [WD_W-1:0]   WD_LOAD  = WD_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  num_q;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [INFL_W-1:0] inflight_q;
    logic [WD_W-1:0]   wd_cnt_q;
    logic              cfg_accept;
    logic              issue;
    logic              comp;
    logic              wd_expired;
    logic              abort;

    assign cfg_accept     = (state_q == IDLE) && cfg_start;
    assign ap.ap_start    = (state_q == ISSUE) && (inflight_q < INFL_MAX);
    assign ap.ap_continue = ~sink_hold;
    assign issue          = ap.ap_start && ap.ap_ready;
    // A completion with nothing in flight is a stray ap_done and is dropped.
    assign comp           = (state_q != IDLE) && ap.ap_done && ap.ap_continue &&
                            (inflight_q != '0);
    // Any handshake this cycle counts as progress, even on the terminal count.
    assign wd_expired     = (wd_cnt_q == '0) && !issue && !comp;
    assign busy           = (state_q != IDLE);
    assign run_done       = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) state_d = (cfg_num_txn == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (issue) begin
                    if (issued_cnt + CNT_W'(1) == num_q) state_d = DRAIN;
                    else if (gap_q != '0)                state_d = GAP;
                end else if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            GAP: begin
                if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end else if (gap_cnt_q == '0) begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (done_cnt == num_q) begin
                    state_d = DONE;
                end else if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            inflight_q  <= '0;
            wd_cnt_q    <= WD_LOAD;
            issued_cnt  <= '0;
            done_cnt    <= '0;
            run_cycles  <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q <= state_d;

            if (cfg_accept) begin
                num_q       <= cfg_num_txn;
                gap_q       <= cfg_gap;
                inflight_q  <= '0;
                issued_cnt  <= '0;
                done_cnt    <= '0;
                run_cycles  <= '0;
                err_timeout <= 1'b0;
            end else begin
                if (issue) issued_cnt <= issued_cnt + CNT_W'(1);
                if (comp)  done_cnt   <= done_cnt + CNT_W'(1);
                case ({issue, comp})
                    2'b10:   inflight_q <= inflight_q + INFL_W'(1);
                    2'b01:   inflight_q <= inflight_q - INFL_W'(1);
                    default: inflight_q <= inflight_q;
                endcase
                if (busy && (run_cycles != '1)) run_cycles <= run_cycles + TS_W'(1);
                if (abort) err_timeout <= 1'b1;
            end

            // GAP occupies cfg_gap cycles: load gap-1 and leave on zero.
            if (issue)
                gap_cnt_q <= gap_q - GAP_W'(1);
            else if ((state_q == GAP) && (gap_cnt_q != '0))
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);

            if ((state_q == IDLE) || (state_d != state_q) || issue || comp)
                wd_cnt_q <= WD_LOAD;
            else if (wd_cnt_q != '0)
                wd_cnt_q <= wd_cnt_q - WD_W'(1);
        end
    end

`ifdef AP_SEQ_LAT_STATS_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] head_ts;
    logic [TS_W-1:0] lat_now;

    always_ff @(posedge clock) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    ap_seq_ts_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TS_W)
    ) u_ts_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (cfg_accept),
        .push      (issue),
        .push_data (ts_q),
        .pop       (comp),
        .head      (head_ts)
    );

    // Modular difference keeps the latency right across timestamp wrap.
    assign lat_now = ts_q - head_ts;

    always_ff @(posedge clock) begin
        if (reset || cfg_accept) begin
            lat_last <= '0;
            lat_min  <= '1;
            lat_max  <= '0;
        end else if (comp) begin
            lat_last <= lat_now;
            if (lat_now < lat_min) lat_min <= lat_now;
            if (lat_now > lat_max) lat_max <= lat_now;
        end
    end
`endif

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
`timescale 1ns/1ps
module tb_ap_ctrl_sequencer;
    localparam int CNT_W  = 16;
    localparam int TS_W   = 32;
    localparam int MAXI   = 2;
    localparam int TMO    = 64;
    localparam int WD_TMO = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // main instance
    logic             cfg_start = 1'b0;
    logic [CNT_W-1:0] cfg_num_txn = '0;
    logic [7:0]       cfg_gap = '0;
    logic             sink_hold = 1'b0;
    logic             busy, run_done, err_timeout;
    logic [CNT_W-1:0] issued_cnt, done_cnt;
    logic [TS_W-1:0]  run_cycles;
    ap_ctrl_sequencer_if kif();

    // watchdog instance (short timeout, kernel never responds)
    logic             wd_cfg_start = 1'b0;
    logic [CNT_W-1:0] wd_num = '0;
    logic [7:0]       wd_gap = '0;
    logic             wd_hold = 1'b0;
    logic             wd_busy, wd_run_done, wd_err;
    logic [CNT_W-1:0] wd_issued, wd_done;
    logic [TS_W-1:0]  wd_cycles;
    ap_ctrl_sequencer_if wif();

`ifdef AP_SEQ_LAT_STATS_EN
    logic [TS_W-1:0] lat_last, lat_min, lat_max;
    logic [TS_W-1:0] wd_lat_last, wd_lat_min, wd_lat_max;
`endif

    ap_ctrl_sequencer #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAXI), .TS_W(TS_W), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .cfg_start(cfg_start), .cfg_num_txn(cfg_num_txn),
        .cfg_gap(cfg_gap), .sink_hold(sink_hold), .ap(kif), .busy(busy), .run_done(run_done),
        .err_timeout(err_timeout), .issued_cnt(issued_cnt), .done_cnt(done_cnt),
        .run_cycles(run_cycles)
`ifdef AP_SEQ_LAT_STATS_EN
        , .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max)
`endif
    );

    ap_ctrl_sequencer #(.CNT_W(CNT_W), .MAX_INFLIGHT(4), .TS_W(TS_W), .TIMEOUT(WD_TMO)) dut_wd (
        .clock(clock), .reset(reset), .cfg_start(wd_cfg_start), .cfg_num_txn(wd_num),
        .cfg_gap(wd_gap), .sink_hold(wd_hold), .ap(wif), .busy(wd_busy), .run_done(wd_run_done),
        .err_timeout(wd_err), .issued_cnt(wd_issued), .done_cnt(wd_done),
        .run_cycles(wd_cycles)
`ifdef AP_SEQ_LAT_STATS_EN
        , .lat_last(wd_lat_last), .lat_min(wd_lat_min), .lat_max(wd_lat_max)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    // ---------------- behavioural kernel + reference model ----------------
    int  cyc = 0;
    int  ready_mode = 1;    // 0 random, 1 always ready, 2 never ready
    int  fixed_lat = 3;     // 0 -> random latency per invocation
    bit  spurious = 1'b0;   // raise ap_done while nothing is in flight
    int  gap_chk = -1;      // expected ap_start-low cycles between issues, -1 off
    int  model_infl = 0;
    int  run_comp = 0;
    int  run_iss = 0;
    int  low_cnt = 0;
    bit  seen_issue = 1'b0;
    bit  hs_i, hs_c;
    int  done_q[$];

    initial begin
        kif.ap_ready = 1'b0;
        kif.ap_done  = 1'b0;
        wif.ap_ready = 1'b0;
        wif.ap_done  = 1'b0;
    end

    always begin
        @(negedge clock);
        #1;
        cyc++;
        case (ready_mode)
            0:       kif.ap_ready = ($urandom_range(0, 3) != 0);
            1:       kif.ap_ready = 1'b1;
            default: kif.ap_ready = 1'b0;
        endcase
        if (done_q.size() > 0 && done_q[0] <= cyc) kif.ap_done = 1'b1;
        else                                       kif.ap_done = spurious && (model_infl == 0);
        #1;
        if (reset) begin
            done_q.delete();
            model_infl = 0;
            seen_issue = 1'b0;
        end else begin
            hs_i = kif.ap_start && kif.ap_ready;
            hs_c = kif.ap_done && kif.ap_continue && (model_infl > 0);
            if (model_infl >= MAXI) check("start_low_at_max_inflight", longint'(kif.ap_start), 0);
            if (gap_chk >= 0 && !kif.ap_start) low_cnt++;
            if (hs_c) begin
                if (done_q.size() > 0) void'(done_q.pop_front());
                model_infl--;
                run_comp++;
            end
            if (hs_i) begin
                done_q.push_back(cyc + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 12))));
                model_infl++;
                run_iss++;
                check("inflight_bound_ok", longint'(model_infl <= MAXI), 1);
                if (gap_chk >= 0) begin
                    if (seen_issue) check("gap_low_cycles", low_cnt, gap_chk);
                    seen_issue = 1'b1;
                    low_cnt = 0;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        int iss;
        int dn;
        bit err;
        int cycles;   // -1: not checked
    } exp_t;
    exp_t sb_q[$];
    exp_t e;
    int runs_seen = 0;
    int runs_exp = 0;

    always begin
        @(negedge clock);
        #3;
        if (run_done) begin
            runs_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run_done: got run_done=1 expected no pending run");
            end else begin
                e = sb_q.pop_front();
                check("sb_issued_cnt", issued_cnt, e.iss);
                check("sb_done_cnt", done_cnt, e.dn);
                check("sb_err_timeout", err_timeout, longint'(e.err));
                if (e.cycles >= 0) begin
                    @(negedge clock);
                    #3;
                    check("sb_run_cycles", run_cycles, e.cycles);
                end
            end
        end
    end

    task automatic start_run(input int num, input int gap, input int exp_cycles);
        exp_t x;
        x.iss = num; x.dn = num; x.err = 1'b0; x.cycles = exp_cycles;
        sb_q.push_back(x);
        runs_exp++;
        run_comp = 0;
        run_iss = 0;
        cfg_num_txn = CNT_W'(num);
        cfg_gap = 8'(gap);
        cfg_start = 1'b1;
        @(negedge clock);
        cfg_start = 1'b0;
    endtask

    task automatic wait_runs();
        int k = 0;
        while (runs_seen < runs_exp && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check("run_completed_in_budget", runs_seen, runs_exp);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int snap;
        int num;

        sink_hold = 1'b1;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_run_done", run_done, 0);
        check("rst_err", err_timeout, 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_done", done_cnt, 0);
        check("rst_cycles", run_cycles, 0);
        check("rst_ap_start", kif.ap_start, 0);
        check("rst_continue_held", kif.ap_continue, 0);
        sink_hold = 1'b0;
        tick(1);
        check("rst_continue_free", kif.ap_continue, 1);
        reset = 1'b0;
        tick(2);

        // 4 invocations, immediate ready, 3-cycle kernel
        ready_mode = 1; fixed_lat = 3;
        start_run(4, 0, -1);
        wait_runs();

        // 8 invocations, slow kernel: in-flight limit exercised
        fixed_lat = 10;
        start_run(8, 0, -1);
        wait_runs();

        // gap of 2 cycles between issues
        fixed_lat = 1; gap_chk = 2; seen_issue = 1'b0; low_cnt = 0;
        start_run(3, 2, -1);
        wait_runs();
        gap_chk = -1;

        // downstream stall with ap_done pending
        fixed_lat = 3;
        start_run(2, 0, -1);
        k = 0;
        while (!kif.ap_done && k < 50) begin tick(1); k++; end
        sink_hold = 1'b1;
        snap = run_comp;
        tick(20);
        check("hold_continue_low", kif.ap_continue, 0);
        check("hold_done_frozen", done_cnt, snap);
        sink_hold = 1'b0;
        wait_runs();

        // empty run
        start_run(0, 0, 1);
        check("num0_run_done_next_cycle", run_done, 1);
        wait_runs();

        // stray ap_done before anything is in flight
        ready_mode = 2; spurious = 1'b1; fixed_lat = 2;
        start_run(1, 0, -1);
        tick(5);
        ready_mode = 1;
        wait_runs();
        spurious = 1'b0;
        tick(3);

        // randomized runs with a cfg_start attempt while busy
        ready_mode = 0; fixed_lat = 0;
        for (int r = 0; r < 6; r++) begin
            num = int'($urandom_range(1, 8));
            start_run(num, int'($urandom_range(0, 3)), -1);
            tick(2);
            if (busy) begin
                cfg_num_txn = CNT_W'(99);
                cfg_gap = 8'd0;
                cfg_start = 1'b1;
                tick(1);
                cfg_start = 1'b0;
            end
            wait_runs();
        end

`ifdef AP_SEQ_LAT_STATS_EN
        ready_mode = 1; fixed_lat = 5;
        start_run(4, 0, -1);
        wait_runs();
        check("lat_min", lat_min, 5);
        check("lat_max", lat_max, 5);
        check("lat_last", lat_last, 5);
`endif

        // reset during DRAIN
        ready_mode = 1; fixed_lat = 20;
        start_run(2, 0, -1);
        k = 0;
        while (issued_cnt != CNT_W'(2) && k < 30) begin tick(1); k++; end
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        void'(sb_q.pop_back());
        runs_exp--;
        check("midrst_busy", busy, 0);
        check("midrst_ap_start", kif.ap_start, 0);
        check("midrst_issued", issued_cnt, 0);
        check("midrst_done", done_cnt, 0);
        check("midrst_cycles", run_cycles, 0);
        check("midrst_run_done", run_done, 0);
        tick(30);
        check("midrst_no_run_done", runs_seen, runs_exp);

        // watchdog: kernel never ready
        wd_num = CNT_W'(2);
        wd_cfg_start = 1'b1;
        tick(1);
        wd_cfg_start = 1'b0;
        check("wd_busy", wd_busy, 1);
        check("wd_ap_start", wif.ap_start, 1);
        k = 0;
        while (!wd_run_done && k < 100) begin tick(1); k++; end
        check("wd_run_done_delay", k, WD_TMO + 1);
        check("wd_err", wd_err, 1);
        check("wd_issued", wd_issued, 0);
        tick(1);
        check("wd_run_cycles", wd_cycles, WD_TMO + 2);
        tick(3);
        check("wd_err_sticky", wd_err, 1);
        wd_num = '0;
        wd_cfg_start = 1'b1;
        tick(1);
        wd_cfg_start = 1'b0;
        check("wd_err_cleared", wd_err, 0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
